l2_tcdm_responder: RTL and testbench

Synthesizable L2 memory slave. Answers the TCDM-style request/grant/rvalid interface driven by the uDMA subsystem L2 read-only and write-only ports; one instance serves each port. It is backed by a word-addressed memory array, inserts a programmable grant stall, and returns rvalid exactly one cycle after grant. It also keeps transaction counters and a sticky out-of-range error for the bench and for FPGA bring-up.

---
 rtl/l2_tcdm_responder.sv | 150 +++++++++++++++
 tb/tb_l2_tcdm_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_tcdm_responder.sv
// TCDM-style L2 slave: word array, programmable grant stall, 1-cycle rvalid.
// Define L2_RESP_RANDOM_STALL_EN to mask the stall with a per-grant LFSR.
module l2_tcdm_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 2048,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1C00_0000
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_resetn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    wen_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    input  logic [3:0]              stall_cycles_i,
    output logic                    err_o,
    output logic [15:0]             rd_count_o,
    output logic [15:0]             wr_count_o
);

    localparam int                    BE_W     = DATA_WIDTH / 8;
    localparam int                    IDX_W    = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WORDS_A  = ADDR_WIDTH'(MEM_WORDS);
    localparam logic [DATA_WIDTH-1:0] OOR_DATA = DATA_WIDTH'(32'hBADC_AB1E);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;

    logic [3:0]            stall_eff;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [IDX_W-1:0]      mem_idx;
    logic                  in_range;
    logic                  acc;
    logic                  rd_acc;
    logic                  wr_acc;

    assign word_off = (addr_i - BASE_ADDR) >> 2;
    assign mem_idx  = word_off[IDX_W-1:0];
    assign in_range = (addr_i >= BASE_ADDR) && (word_off < WORDS_A);

    assign gnt_o  = req_i & (wait_cnt_q >= stall_eff);
    assign acc    = req_i & gnt_o;
    assign rd_acc = acc & wen_i;
    assign wr_acc = acc & ~wen_i;

`ifdef L2_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  mask_q, mask_d;

    // Mask is latched at grant; the live stall input is applied through it.
    always_comb begin
        lfsr_d = lfsr_q;
        mask_d = mask_q;
        if (acc) begin
            mask_d = lfsr_q[3:0];
            lfsr_d = {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_eff = (mask_q == 4'h0) ? stall_cycles_i
                                        : (mask_q & stall_cycles_i);

    always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            lfsr_q <= 16'hACE1;
            mask_q <= 4'h0;
        end else begin
            lfsr_q <= lfsr_d;
            mask_q <= mask_d;
        end
    end
`else
    assign stall_eff = stall_cycles_i;
`endif

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_i || gnt_o) begin
            wait_cnt_d = 4'h0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'h1;
        end
    end

    always_comb begin
        rvalid_d = acc;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_acc) begin
            rdata_d  = in_range ? mem_q[mem_idx] : OOR_DATA;
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (wr_acc) begin
            rdata_d  = '0;
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (acc && !in_range) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            wait_cnt_q <= 4'h0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            rd_cnt_q   <= 16'h0;
            wr_cnt_q   <= 16'h0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Array is deliberately not reset; a granted write survives a later reset.
    always_ff @(posedge sys_clk_i) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;
    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;

endmodule

// File: tb/tb_l2_tcdm_responder.sv
// Bench for l2_tcdm_responder: directed table, stall/reset corners,
// random traffic against a word-array reference model.
`timescale 1ns/1ps
module tb_l2_tcdm_responder;

    localparam logic [31:0] BASE  = 32'h1C00_0000;
    localparam int          WORDS = 2048;
    localparam logic [31:0] OOR   = 32'hBADC_AB1E;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  stall;
    logic        err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [WORDS];
    logic [15:0] m_rd;
    logic [15:0] m_wr;
    logic        m_err;

    l2_tcdm_responder dut (
        .sys_clk_i      (clk),
        .sys_resetn_i   (rst_n),
        .req_i          (req),
        .gnt_o          (gnt),
        .wen_i          (wen),
        .addr_i         (addr),
        .be_i           (be),
        .wdata_i        (wdata),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .stall_cycles_i (stall),
        .err_o          (err),
        .rd_count_o     (rd_cnt),
        .wr_count_o     (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request fields must hold while waiting for grant.
    assert property (@(posedge clk) disable iff (!rst_n)
        (req && !gnt) |=> (req && $stable(wen) && $stable(addr)
                           && $stable(be) && $stable(wdata)));

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        return (a >= BASE) && (idx < WORDS);
    endfunction

    task automatic model_apply(input bit rd, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] wd,
                               output logic [31:0] exp);
        int idx;
        idx = int'((a - BASE) >> 2);
        if (!in_rng(a)) m_err = 1'b1;
        if (rd) begin
            exp  = in_rng(a) ? mm[idx] : OOR;
            m_rd = m_rd + 16'd1;
        end else begin
            exp = 32'h0;
            if (in_rng(a)) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mm[idx][8*k +: 8] = wd[8*k +: 8];
            end
            m_wr = m_wr + 16'd1;
        end
    endtask

    task automatic chk_resp(input logic [31:0] exp);
        chk("rvalid", 32'(rvalid), 32'd1);
        chk("rdata", rdata, exp);
        chk("rd_count", 32'(rd_cnt), 32'(m_rd));
        chk("wr_count", 32'(wr_cnt), 32'(m_wr));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // Called at a negedge; returns at the negedge after the response.
    task automatic xfer(input bit rd, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd,
                        input int st, input bit drop,
                        input bit use_exp, input logic [31:0] exp_in);
        logic [31:0] exp;
        req   = 1'b1;
        wen   = rd;
        addr  = a;
        be    = b;
        wdata = wd;
        stall = st[3:0];
        for (int c = 0; c <= st; c++) begin
            if (c > 0) begin
                @(negedge clk);
                chk("rvalid_in_stall", 32'(rvalid), 32'd0);
            end
            #1;
            chk("gnt", 32'(gnt), 32'(c == st));
        end
        model_apply(rd, a, b, wd, exp);
        if (use_exp) exp = exp_in;
        @(negedge clk);
        chk_resp(exp);
        if (drop) req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_rd  = 16'h0;
        m_wr  = 16'h0;
        m_err = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] wd;
        int          st;
        bit          drop;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] e;
    logic [31:0] ra;
    bit          rrd;

    initial begin
        tbl[0] = '{0, BASE,             4'hF, 32'hDEADBEEF, 0, 0, 32'h0};
        tbl[1] = '{1, BASE,             4'h0, 32'h0,        0, 1, 32'hDEADBEEF};
        tbl[2] = '{1, BASE,             4'h0, 32'h0,        3, 1, 32'hDEADBEEF};
        tbl[3] = '{0, BASE + 8,         4'hF, 32'h11223344, 1, 0, 32'h0};
        tbl[4] = '{0, BASE + 8,         4'h5, 32'hAABBCCDD, 0, 0, 32'h0};
        tbl[5] = '{1, BASE + 8,         4'h0, 32'h0,        2, 1, 32'h11BB33DD};
        tbl[6] = '{1, BASE + 4*WORDS,   4'h0, 32'h0,        0, 1, OOR};
        tbl[7] = '{0, BASE - 4,         4'hF, 32'h01020304, 0, 0, 32'h0};
        tbl[8] = '{0, BASE + 4*2047,    4'hF, 32'hCAFEF00D, 0, 0, 32'h0};
        tbl[9] = '{1, BASE + 4*2047 + 3, 4'h0, 32'h0,       1, 1, 32'hCAFEF00D};

        rst_n = 1'b0;
        req   = 1'b0;
        wen   = 1'b1;
        addr  = BASE;
        be    = 4'h0;
        wdata = 32'h0;
        stall = 4'h0;
        m_rd  = 16'h0;
        m_wr  = 16'h0;
        m_err = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_count", 32'(rd_cnt), 32'd0);
        chk("rst_wr_count", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            xfer(tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].wd,
                 tbl[i].st, tbl[i].drop, 1'b1, tbl[i].exp);
        req = 1'b0;
        @(negedge clk);

        // Stall lowered mid-wait takes effect against the current count.
        req   = 1'b1;
        wen   = 1'b1;
        addr  = BASE + 8;
        stall = 4'd6;
        #1;
        chk("chg_gnt0", 32'(gnt), 32'd0);
        @(negedge clk);
        #1;
        chk("chg_gnt1", 32'(gnt), 32'd0);
        @(negedge clk);
        stall = 4'd2;
        #1;
        chk("chg_gnt2", 32'(gnt), 32'd1);
        model_apply(1'b1, BASE + 8, 4'h0, 32'h0, e);
        @(negedge clk);
        chk_resp(e);
        req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            xfer(1'b0, BASE + 32'(4*i), 4'hF, $urandom, $urandom_range(0, 2),
                 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 300; i++) begin
            rrd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       ra = BASE - 32'(4 * $urandom_range(1, 8));
                1:       ra = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 64));
                default: ra = BASE + 32'(4 * $urandom_range(0, 15))
                              + 32'($urandom_range(0, 3));
            endcase
            xfer(rrd, ra, 4'($urandom), $urandom, $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 1'b0, 32'h0);
        end
        req = 1'b0;
        @(negedge clk);

        // Granted write survives reset; pending response is dropped.
        xfer(1'b0, BASE + 12, 4'hF, 32'h5555AAAA, 5, 1'b0, 1'b0, 32'h0);
        xfer(1'b1, BASE + 12, 4'h0, 32'h0, 5, 1'b0, 1'b1, 32'h5555AAAA);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_rd", 32'(rd_cnt), 32'd0);
        chk("mid_rst_wr", 32'(wr_cnt), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        m_rd  = 16'h0;
        m_wr  = 16'h0;
        m_err = 1'b0;
        @(negedge clk);
        chk("mid_rst_late", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b1, BASE + 12, 4'h0, 32'h0, 5, 1'b1, 1'b1, 32'h5555AAAA);
        @(negedge clk);

        do_reset();
        @(negedge clk);
        for (int i = 0; i < 65537; i++)
            xfer(1'b1, BASE, 4'h0, 32'h0, 0, i == 65536, 1'b0, 32'h0);
        chk("rd_wrap", 32'(rd_cnt), 32'h0001);
        @(negedge clk);
        chk("rvalid_idle", 32'(rvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
